// File: rtl/liner_ctrl.sv
// Sequencer feeding the serial Enocoro Liner byte by byte; results go out through a 2-entry FIFO.
// Latency: accept -> out_valid 3 cycles; throughput 1 op / 2 cycles; in_ready throttles on FIFO occupancy.
module liner_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    output logic [7:0]       lin_data_in,
    output logic             lin_mux_control,
    input  logic [7:0]       lin_data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PAIR   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [7:0]       r_u1_hold;
    logic [7:0]       r_v0_hold;
    logic [15:0]      r_fifo [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic [CNT_W-1:0] r_op_count;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    logic [7:0]       w_lin_data;
    logic             w_mux;

    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        w_lin_data = 8'h00;
        w_mux      = 1'b0;
        w_push     = 1'b0;
        w_accept   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = (r_count != 2'd2);
            end
            S_PAIR: begin
                w_lin_data = r_u1_hold;
                w_next     = S_FINISH;
            end
            S_FINISH: begin
                w_mux      = 1'b1;
                w_push     = 1'b1;
                // Pre-push occupancy only: a same-cycle pop is deliberately not credited.
                w_in_ready = (r_count == 2'd0);
                w_next     = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        w_accept = in_valid & w_in_ready;
        if (w_accept) begin
            w_lin_data = in_data[15:8];
            w_next     = S_PAIR;
        end
    end

    assign w_pop = out_ready && (r_count != 2'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_u1_hold  <= 8'h00;
            r_v0_hold  <= 8'h00;
            r_fifo[0]  <= 16'h0000;
            r_fifo[1]  <= 16'h0000;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_op_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_u1_hold <= in_data[7:0];
            end
            if (r_state == S_PAIR) begin
                r_v0_hold <= lin_data_out;
            end
            if (w_push) begin
                r_fifo[r_wr_ptr] <= {r_v0_hold, lin_data_out};
                r_wr_ptr         <= ~r_wr_ptr;
                r_op_count       <= r_op_count + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 2'd1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 2'd1;
            end
        end
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (!reset_n)
        !(w_push && (r_count == 2'd2)));

    assign in_ready        = w_in_ready;
    assign lin_data_in     = w_lin_data;
    assign lin_mux_control = w_mux;
    assign out_valid       = (r_count != 2'd0);
    assign out_data        = (r_count != 2'd0) ? r_fifo[r_rd_ptr] : 16'h0000;
    assign busy            = (r_state != S_IDLE);
    assign op_count        = r_op_count;

endmodule

// File: tb/tb_liner_ctrl.sv
// Bench for liner_ctrl: Liner stand-in, scoreboard queue fed at accept, monitor checking every pop.
module tb_liner_ctrl;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_data;
    logic [7:0]       lin_data_in;
    logic             lin_mux_control;
    logic [7:0]       lin_data_out;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_data;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    int          checks = 0;
    int          errors = 0;
    int          acc_cnt = 0;
    int          cyc = 0;
    logic [15:0] exp_q [$];
    bit          rnd_rdy_on = 0;

    liner_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .lin_data_in(lin_data_in), .lin_mux_control(lin_mux_control),
        .lin_data_out(lin_data_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Liner stand-in: one byte of history per cycle; mux 0 adds, mux 1 mixes with doubling.
    logic [7:0] l_d1, l_d2;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            l_d1 <= 8'h00;
            l_d2 <= 8'h00;
        end else begin
            l_d1 <= lin_data_in;
            l_d2 <= l_d1;
        end
    end
    function automatic logic [7:0] xt(input logic [7:0] b);
        xt = {b[6:0], 1'b0} ^ (b[7] ? 8'h1D : 8'h00);
    endfunction
    assign lin_data_out = lin_mux_control ? (l_d2 ^ xt(l_d1)) : (l_d1 ^ lin_data_in);

    // Reference: GF(2^8) doubling mod 0x11D done with plain integer arithmetic.
    function automatic logic [15:0] ref_l(input logic [15:0] d);
        int u0, u1, m;
        u0 = int'(d[15:8]);
        u1 = int'(d[7:0]);
        m  = u1 * 2;
        if (m >= 256) m = m ^ 'h11D;
        ref_l = 16'((((u0 ^ u1) & 255) << 8) | ((u0 ^ m) & 255));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: sampled at negedge, away from the edge where inputs/state change.
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            acc_cnt = 0;
        end else begin
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_l(in_data));
                acc_cnt++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %0h expected none", out_data);
                end else begin
                    check("result", {16'h0, out_data}, {16'h0, exp_q.pop_front()});
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rnd_rdy_on) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic [15:0] d);
        bit ok = 0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            in_valid = 1'b0;
            checks++;
            errors++;
            $display("FAIL send_timeout: operand %0h not accepted within 60 cycles", d);
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 16'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
        idle(1);
    endtask

    initial begin
        int last, n, base;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0;
        out_ready = 1'b1;
        idle(2);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_op_count", 32'(op_count), 0);
        check("rst_lin", {23'h0, lin_mux_control, lin_data_in}, 0);
        reset_n = 1'b1;
        idle(1);

        // Single operation with latency measurement
        send(16'h1234);
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (out_valid) begin
                n = i;
                break;
            end
        end
        check("latency", 32'(n), 3);
        idle(2);
        check("op_count_single", 32'(op_count), 1);

        // Edge values; results checked by the monitor
        send(16'h0080);
        send(16'hFFFF);
        send(16'h0000);
        idle(5);
        check("op_count_edges", 32'(op_count), 4);

        // Back-to-back streaming: accepts exactly 2 cycles apart
        last = 0;
        for (int i = 0; i < 8; i++) begin
            send(16'($urandom));
            if (i > 0) check("stream_spacing", 32'(cyc - last), 2);
            last = cyc;
        end
        idle(5);
        check("op_count_stream", 32'(op_count), 32'((4 + 8) % 16));

        // Backpressure: only 2 of 4 accepted until the sink drains
        out_ready = 1'b0;
        base = acc_cnt;
        fork
            begin
                for (int i = 0; i < 4; i++) send(16'($urandom));
            end
            begin
                idle(20);
                check("bp_accepts", 32'(acc_cnt - base), 2);
                check("bp_in_ready", 32'(in_ready), 0);
                check("bp_out_valid", 32'(out_valid), 1);
                out_ready = 1'b1;
            end
        join
        idle(6);
        check("bp_drained", 32'(exp_q.size()), 0);
        check("op_count_bp", 32'(op_count), 32'((12 + 4) % 16));

        // Reset during PAIR
        send(16'h5555);
        check("pair_busy", 32'(busy), 1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_in_ready", 32'(in_ready), 1);
        check("mid_rst_out", {15'h0, out_valid, out_data}, 0);
        check("mid_rst_lin", {23'h0, lin_mux_control, lin_data_in}, 0);
        check("mid_rst_op_count", 32'(op_count), 0);
        idle(2);
        reset_n = 1'b1;
        idle(1);
        send(16'h1234);
        idle(5);
        check("op_count_after_rst", 32'(op_count), 1);
        check("after_rst_drained", 32'(exp_q.size()), 0);

        // Counter wrap: 2^CNT_W + 1 operations
        do_reset();
        for (int i = 0; i < 17; i++) send(16'($urandom));
        idle(5);
        check("op_count_wrap", 32'(op_count), 1);

        // Randomised traffic with random sink stalls
        do_reset();
        rnd_rdy_on = 1;
        for (int i = 0; i < 40; i++) begin
            send(16'($urandom));
            idle($urandom_range(0, 2));
        end
        rnd_rdy_on = 0;
        idle(2);
        out_ready = 1'b1;
        idle(8);
        check("rand_drained", 32'(exp_q.size()), 0);
        check("op_count_rand", 32'(op_count), 32'(40 % 16));
        check("rand_idle_busy", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "timeout");
    end
endmodule
